// File: rtl/systolic_psum_collector_pkg.sv
// systolic_psum_collector_pkg: shared defaults, column-index width helper and
// drain FSM encoding for the systolic partial-sum collector.
package systolic_psum_collector_pkg;

    localparam int PSUM_WIDTH_DEF = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    function automatic int col_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_psum_collector_column_fifo.sv
// psum_column_fifo: per-column {tlast, tdata} buffer; ready is !full, so a
// full FIFO never accepts a word even when it is popped in the same cycle.
module psum_column_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    input  logic             i_pop,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic             w_full;
    logic             w_wr_en;
    logic             w_rd_en;

    // Extra pointer bit distinguishes full from empty.
    assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_empty = (r_wr == r_rd);
    assign o_ready = !w_full;
    assign w_wr_en = i_push && !w_full;
    assign w_rd_en = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_wr_en) r_wr <= r_wr + (AW+1)'(1);
            if (w_rd_en) r_rd <= r_rd + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/systolic_psum_collector.sv
// systolic_psum_collector: deskews the bottom-row PE partial-sum streams through
// per-column FIFOs and serializes them column by column onto one AXI-Stream.
module systolic_psum_collector
    import systolic_psum_collector_pkg::*;
#(
    parameter int  PE_NUMBER_I = 4,
    parameter int  PSUM_WIDTH  = PSUM_WIDTH_DEF,
    parameter int  FIFO_DEPTH  = 4,
    localparam int UW          = col_idx_w(PE_NUMBER_I)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [PE_NUMBER_I*PSUM_WIDTH-1:0] s_axis_d_tdata,
    input  logic [PE_NUMBER_I-1:0]            s_axis_d_tvalid,
    input  logic [PE_NUMBER_I-1:0]            s_axis_d_tlast,
    output logic [PE_NUMBER_I-1:0]            s_axis_d_tready,
    output logic [PSUM_WIDTH-1:0]             m_axis_tdata,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    output logic [UW-1:0]                     m_axis_tuser,
    output logic [15:0]                       row_count,
    output logic                              err_unalligned_data
);

    logic [PE_NUMBER_I-1:0] w_empty;
    logic [PSUM_WIDTH:0]    w_head [PE_NUMBER_I];
    logic [PSUM_WIDTH:0]    w_word;
    logic                   w_ptr_last;
    logic                   w_avail;
    logic                   w_pop;

    state_e                 r_state;
    logic [UW-1:0]          r_ptr;
    logic                   r_row_last;
    logic [PSUM_WIDTH-1:0]  r_tdata;
    logic [UW-1:0]          r_tuser;
    logic                   r_tvalid;
    logic                   r_tlast;
    logic [15:0]            r_rows;
    logic                   r_err;

    genvar c;
    for (c = 0; c < PE_NUMBER_I; c++) begin : g_col
        psum_column_fifo #(
            .WIDTH(PSUM_WIDTH + 1),
            .DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk    (clk),
            .rst    (rst),
            .i_push (s_axis_d_tvalid[c]),
            .i_data ({s_axis_d_tlast[c], s_axis_d_tdata[c*PSUM_WIDTH +: PSUM_WIDTH]}),
            .o_ready(s_axis_d_tready[c]),
            .i_pop  (w_pop && (r_ptr == UW'(c))),
            .o_empty(w_empty[c]),
            .o_data (w_head[c])
        );
    end

    assign w_word     = w_head[r_ptr];
    assign w_ptr_last = (r_ptr == UW'(PE_NUMBER_I - 1));
    // IDLE waits on column 0 to start a row; DRAIN strictly follows ptr, never skipping.
    assign w_avail    = (r_state == ST_IDLE) ? !w_empty[0] : !w_empty[r_ptr];
    assign w_pop      = w_avail && (!r_tvalid || m_axis_tready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_row_last <= 1'b0;
            r_tdata    <= '0;
            r_tuser    <= '0;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_rows     <= '0;
            r_err      <= 1'b0;
        end else if (w_pop) begin
            r_tdata  <= w_word[PSUM_WIDTH-1:0];
            r_tuser  <= r_ptr;
            r_tvalid <= 1'b1;
            r_tlast  <= w_ptr_last && w_word[PSUM_WIDTH];
            r_ptr    <= w_ptr_last ? '0 : r_ptr + UW'(1);
            r_state  <= w_ptr_last ? ST_IDLE : ST_DRAIN;
            r_rows   <= w_ptr_last ? r_rows + 16'd1 : r_rows;
            // Column 0 sets the row's tlast reference; any later disagreement is sticky.
            if (r_ptr == '0) r_row_last <= w_word[PSUM_WIDTH];
            else if (w_word[PSUM_WIDTH] != r_row_last) r_err <= 1'b1;
        end else if (m_axis_tready) begin
            r_tvalid <= 1'b0;
        end
    end

    assign m_axis_tdata        = r_tdata;
    assign m_axis_tuser        = r_tuser;
    assign m_axis_tvalid       = r_tvalid;
    assign m_axis_tlast        = r_tlast;
    assign row_count           = r_rows;
    assign err_unalligned_data = r_err;

endmodule

// File: tb/tb_systolic_psum_collector.sv
// tb_systolic_psum_collector: directed rows per column, checked against a
// per-column queue model of the round-robin serializer plus literal expectations.
module tb_systolic_psum_collector;

    localparam int I  = 4;
    localparam int W  = 32;
    localparam int D  = 4;
    localparam int UW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [I*W-1:0] s_data  = '0;
    logic [I-1:0]   s_valid = '0;
    logic [I-1:0]   s_last  = '0;
    logic [I-1:0]   s_ready;
    logic [W-1:0]   m_data;
    logic           m_valid;
    logic           m_last;
    logic           m_ready = 1'b1;
    logic [UW-1:0]  m_user;
    logic [15:0]    row_count;
    logic           err;

    systolic_psum_collector #(
        .PE_NUMBER_I(I),
        .PSUM_WIDTH (W),
        .FIFO_DEPTH (D)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .s_axis_d_tdata     (s_data),
        .s_axis_d_tvalid    (s_valid),
        .s_axis_d_tlast     (s_last),
        .s_axis_d_tready    (s_ready),
        .m_axis_tdata       (m_data),
        .m_axis_tvalid      (m_valid),
        .m_axis_tlast       (m_last),
        .m_axis_tready      (m_ready),
        .m_axis_tuser       (m_user),
        .row_count          (row_count),
        .err_unalligned_data(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    logic [W:0]    sq [I][$];
    int            hold [I];
    logic [W:0]    mq [I][$];
    logic [I-1:0]  acc_now = '0;
    int            acc [I];
    int            hs_cyc [I];
    int            exp_col = 0;
    logic          m_first = 1'b0;
    logic          m_err = 1'b0;
    int            m_rows = 0;
    int            out_cnt = 0;
    int            first_v_cyc = -1;
    int            last_out_cyc = 0;
    logic          p_stall = 1'b0;
    logic [W-1:0]  p_data;
    logic [UW-1:0] p_user;
    logic          p_last;
    logic [W-1:0]  log_d [$];
    logic [UW-1:0] log_u [$];
    logic          log_l [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: each column is a queue; output walks columns 0..I-1 in order.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            for (int c = 0; c < I; c++) begin
                mq[c] = {};
                acc[c] = 0;
                hs_cyc[c] = 0;
            end
            acc_now = '0;
            exp_col = 0;
            m_err = 1'b0;
            m_rows = 0;
            out_cnt = 0;
            first_v_cyc = -1;
            p_stall = 1'b0;
            log_d = {};
            log_u = {};
            log_l = {};
        end else begin
            for (int c = 0; c < I; c++) begin
                acc_now[c] = s_valid[c] && s_ready[c];
                if (acc_now[c]) begin
                    mq[c].push_back({s_last[c], s_data[c*W +: W]});
                    acc[c]++;
                    hs_cyc[c] = cyc;
                end
            end
            if (m_valid && first_v_cyc < 0) first_v_cyc = cyc;
            if (p_stall) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, p_data);
                chk("hold_user", m_user, p_user);
                chk("hold_last", m_last, p_last);
            end
            if (m_valid && m_ready) begin
                if (mq[exp_col].size() == 0) begin
                    chk("unexpected_word", m_data, 64'hdead);
                end else begin
                    logic [W:0] w;
                    w = mq[exp_col].pop_front();
                    if (exp_col == 0) m_first = w[W];
                    else if (w[W] != m_first) m_err = 1'b1;
                    if (exp_col == I - 1) m_rows++;
                    chk("out_data", m_data, w[W-1:0]);
                    chk("out_user", m_user, exp_col);
                    chk("out_last", m_last, (exp_col == I - 1) ? w[W] : 1'b0);
                    chk("out_err", err, m_err);
                    chk("out_rows", row_count, m_rows);
                    log_d.push_back(m_data);
                    log_u.push_back(m_user);
                    log_l.push_back(m_last);
                    out_cnt++;
                    last_out_cyc = cyc;
                    exp_col = (exp_col + 1) % I;
                end
            end
            p_stall = m_valid && !m_ready;
            p_data = m_data;
            p_user = m_user;
            p_last = m_last;
        end
    end

    // Per-column driver: presents queue head once its hold cycle is reached.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int c = 0; c < I; c++) begin
                if (rst && acc_now[c] && sq[c].size() > 0) void'(sq[c].pop_front());
                if (rst && sq[c].size() > 0 && cyc >= hold[c]) begin
                    s_valid[c] = 1'b1;
                    s_data[c*W +: W] = sq[c][0][W-1:0];
                    s_last[c] = sq[c][0][W];
                end else begin
                    s_valid[c] = 1'b0;
                end
            end
        end
    end

    task automatic clear_stim();
        for (int c = 0; c < I; c++) begin
            sq[c] = {};
            hold[c] = 0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        clear_stim();
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_ready", s_ready, 4'hF);
    endtask

    task automatic wait_out(input int n, input int budget, input string name);
        int k = 0;
        while (out_cnt < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk(name, out_cnt, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < I; c++) hold[c] = 0;
        #1;
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_user", m_user, 0);
        chk("rst_last", m_last, 0);
        chk("rst_rows", row_count, 0);
        chk("rst_err", err, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rel_ready", s_ready, 4'hF);

        // Skewed single row 10,20,30,40.
        for (int c = 0; c < I; c++) begin
            sq[c].push_back({1'b0, W'(10 * (c + 1))});
            hold[c] = cyc + c;
        end
        wait_out(4, 50, "t1_count");
        for (int i = 0; i < 4; i++) begin
            chk("t1_data", log_d[i], 10 * (i + 1));
            chk("t1_user", log_u[i], i);
        end
        chk("t1_rows", row_count, 1);
        chk("t1_latency", first_v_cyc - hs_cyc[0], 2);

        // Two rows, second row all tlast=1.
        do_reset();
        for (int c = 0; c < I; c++) begin
            sq[c].push_back({1'b0, W'(c + 1)});
            sq[c].push_back({1'b1, W'(c + 5)});
        end
        wait_out(8, 60, "t2_count");
        for (int i = 0; i < 8; i++) chk("t2_last", log_l[i], (i == 7) ? 1 : 0);
        chk("t2_err", err, 0);
        chk("t2_rows", row_count, 2);

        // tlast only on column 2.
        do_reset();
        for (int c = 0; c < I; c++) sq[c].push_back({(c == 2) ? 1'b1 : 1'b0, W'(100 + c)});
        wait_out(4, 50, "t3_count");
        chk("t3_err", err, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("t3_err_sticky", err, 1);
        chk("t3_data3", log_d[3], 103);

        // Backpressure: 6 words per column, sink stalled 20 cycles.
        do_reset();
        m_ready = 1'b0;
        for (int c = 0; c < I; c++)
            for (int k = 0; k < 6; k++) sq[c].push_back({1'b0, W'(c * 16 + k)});
        repeat (20) @(posedge clk);
        @(negedge clk);
        #1;
        chk("t4_ready", s_ready, 4'h0);
        chk("t4_acc0", acc[0], D + 1);
        chk("t4_acc1", acc[1], D);
        chk("t4_acc3", acc[3], D);
        chk("t4_held", m_data, 0);
        @(posedge clk);
        #1 m_ready = 1'b1;
        wait_out(24, 200, "t4_count");
        chk("t4_rows", row_count, 6);
        chk("t4_last_word", log_d[23], 53);

        // Column 3 withheld.
        do_reset();
        for (int c = 0; c < I; c++) sq[c].push_back({1'b0, W'(7 + c)});
        hold[3] = cyc + 14;
        wait_out(3, 30, "t5_count3");
        repeat (4) @(negedge clk);
        #1;
        chk("t5_stall_cnt", out_cnt, 3);
        chk("t5_stall_valid", m_valid, 0);
        wait_out(4, 40, "t5_count4");
        chk("t5_col3_latency", last_out_cyc - hs_cyc[3], 2);
        chk("t5_col3_data", log_d[3], 10);

        // Reset mid-row: one full row, then a partial second row.
        do_reset();
        for (int c = 0; c < I; c++) sq[c].push_back({1'b0, W'(c + 1)});
        for (int c = 0; c < 3; c++) sq[c].push_back({1'b0, W'(c + 21)});
        wait_out(6, 60, "t6_count");
        #2;
        chk("t6_pre_rows", row_count, 1);
        chk("t6_pre_valid", m_valid, 1);
        rst = 1'b0;
        clear_stim();
        #1;
        chk("t6_rst_valid", m_valid, 0);
        chk("t6_rst_rows", row_count, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        for (int c = 0; c < I; c++) sq[c].push_back({1'b0, W'(50 + 10 * c)});
        wait_out(4, 50, "t6_count_new");
        chk("t6_first_user", log_u[0], 0);
        chk("t6_first_data", log_d[0], 50);
        chk("t6_rows_new", row_count, 1);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
